cpu_datapath: RTL and testbench
===============================

# cpu_datapath

Register-file-and-bus datapath driven by the CPU control FSM: it receives the FSM's one-hot bus enables (`en_reg`), bus drivers (`tri_reg`) and ALU strobes (`general_reg`, `addclr`, `xorclr`, `done`), and executes the transfers they describe. It holds R0–R6, the PC, the adder operand/result pair A/G and the XOR operand/result pair B/H. It also resolves the shared bus, exposes the PC to instruction fetch, and flags illegal multi-driver cycles.

## Interface
- `DATA_WIDTH`, 8, width of bus, registers, `data_in`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en_reg`  in  8  one-hot load enables; bit k (0–6) loads Rk, bit 7 loads PC.
- `tri_reg`  in  11  bus drivers; bits 0–6 = R0–R6, bit 7 = PC, bit 8 = `data_in`, bit 9 = H, bit 10 = G.
- `general_reg`  in  6  ALU strobes {a_en, a_tri, g_en, b_en, b_tri, h_en}, MSB first.
- `addclr`  in  1  clear A after this cycle.
- `xorclr`  in  1  clear B after this cycle.
- `done`  in  1  instruction complete; increments PC.
- `data_in`  in  DATA_WIDTH  external load data.
- `dbg_sel`  in  3  selects R0–R6/PC for `dbg_data`.
- `bus`  out  DATA_WIDTH  resolved bus value (combinational).
- `pc`  out  DATA_WIDTH  current PC, to instruction fetch.
- `dbg_data`  out  DATA_WIDTH  selected register (combinational).
- `bus_err`  out  1  sticky contention flag.

## Operation
- Bus sources: `tri_reg` bits, plus `a_tri` (drives A) and `b_tri` (drives B). Together these form 13 possible drivers.
- Exactly one driver asserted → `bus` = that source.
- No driver asserted → `bus` = 0.
- Two or more drivers asserted:
  - `bus` = 0.
  - No register loads from the bus that cycle; all `en_reg`, `a_en` and `b_en` loads are suppressed.
  - `bus_err` sets and holds until reset.
- Loads, taken at the rising edge:
  - `en_reg[k]`: Rk/PC ← `bus`.
  - `a_en`: A ← `bus`.
  - `b_en`: B ← `bus`.
  - More than one `en_reg` bit set is legal; every selected register loads.
- Adder, on `g_en`: G ← (A + `bus`) mod 2^DATA_WIDTH, using the pre-edge A.
- XOR, on `h_en`: H ← B ^ `bus`, using the pre-edge B.
- Clears:
  - `addclr`: A ← 0. This wins over a simultaneous `a_en`.
  - `xorclr`: B ← 0. This wins over a simultaneous `b_en`.
  - A `g_en`/`h_en` asserted in the same cycle as its clear still uses the old operand.
- PC:
  - `done` alone: PC ← PC + 1, wrapping 0xFF → 0x00 at DATA_WIDTH 8.
  - `en_reg[7]` together with `done`: the bus load wins and there is no increment.
- Reset (async, any time including mid-instruction):
  - R0–R6, PC, A, B, G, H cleared to 0.
  - `bus_err` cleared to 0.
  - Combinational outputs follow the cleared state: `pc` = 0, `dbg_data` = 0; `bus` = 0 unless `data_in` is the sole driver.

## Timing
- `bus` and `dbg_data` are combinational from inputs and state; there is no pipeline stage.
- Any transfer completes in one cycle: source selected in cycle n, destination valid after edge n.
- Expected FSM sequences:
  - LOAD / MOVE: 1 cycle.
  - ADD: 3 cycles.
    - c1: A ← Ry.
    - c2: G ← A + Ry, A cleared.
    - c3: Rx ← G.
  - XOR: same three-cycle shape using B/H, with H driven in c3.
- `bus_err` asserts the cycle after the contending edge and stays high.

## Structure
- Shared package `cpu_pkg` holds:
  - DATA_WIDTH default.
  - `tri_reg` bit indices (TRI_G=10, TRI_H=9, TRI_EXT=8, TRI_PC=7).
  - `general_reg` bit positions.
  - Register codes R0–R6/PC.
- One sub-module, `cpu_reg_file`:
  - Eight DATA_WIDTH registers with per-register load enables.
  - PC increment with load-over-increment priority.
  - Async active-low clear.
  - `dbg_sel` read port.
- Bus resolution, A/B/G/H and the error flag stay in `cpu_datapath`.

## Test plan
- Reset: pulse `rst` low mid-ADD (after c1) → every register reads 0, `bus_err`=0, `pc`=0.
- LOAD/MOVE: `data_in`=0x5A, tri bit 8, en bit 3 → R3=0x5A. Next cycle tri bit 3, en bit 6 → R6=0x5A.
- ADD with wrap: R1=0xF0, R2=0x20, then the c1/c2/c3 sequence with Ry=R2 and A pre-loaded from R1 → R1=0x10, A=0 after c2.
- XOR: B←0xCC, then `h_en` with bus=0xAA and `xorclr` → H=0x66, B=0. Then tri bit 9, en bit 0 → R0=0x66.
- PC: `done` 256 times from 0 → PC wraps to 0. `done` together with en bit 7 and bus=0x40 → PC=0x40.
- Contention: tri bits 1 and 2 together with en bit 4 → `bus`=0, R4 unchanged, `bus_err`=1 from the next cycle until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU datapath slice.
// Purely declarative; no latency.
// No flow control; consumers take these as compile-time constants.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // tri_reg bit indices (bits 0-6 are R0-R6)
  localparam int TRI_PC  = 7;
  localparam int TRI_EXT = 8;
  localparam int TRI_H   = 9;
  localparam int TRI_G   = 10;

  // Extra bus drivers appended above tri_reg in the combined driver vector
  localparam int DRV_A   = 11;
  localparam int DRV_B   = 12;
  localparam int NUM_DRV = 13;

  // general_reg bit positions, {a_en, a_tri, g_en, b_en, b_tri, h_en}
  localparam int GEN_A_EN  = 5;
  localparam int GEN_A_TRI = 4;
  localparam int GEN_G_EN  = 3;
  localparam int GEN_B_EN  = 2;
  localparam int GEN_B_TRI = 1;
  localparam int GEN_H_EN  = 0;

  typedef enum logic [2:0] {
    REG_R0 = 3'd0,
    REG_R1 = 3'd1,
    REG_R2 = 3'd2,
    REG_R3 = 3'd3,
    REG_R4 = 3'd4,
    REG_R5 = 3'd5,
    REG_R6 = 3'd6,
    REG_PC = 3'd7
  } reg_code_e;

  // True when two or more drivers are asserted at once
  function automatic logic multi_hot(input logic [NUM_DRV-1:0] v);
    return (v & (v - NUM_DRV'(1))) != '0;
  endfunction

endpackage

// File: rtl/cpu_reg_file.sv
// R0-R6 plus PC with per-register load enables and a debug read port.
// Loads land on the rising edge; read ports are combinational.
// No backpressure; every enabled load is always accepted.
module cpu_reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 ld_en,
  input  logic [DATA_WIDTH-1:0]      ld_dat,
  input  logic                       inc,
  input  logic [2:0]                 dbg_sel,
  output logic [7:0][DATA_WIDTH-1:0] regs,
  output logic [DATA_WIDTH-1:0]      dbg_data
);

  // General registers load from the bus; PC load takes priority over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (ld_en[k]) regs[k] <= ld_dat;
      end
      if (ld_en[REG_PC])  regs[REG_PC] <= ld_dat;
      else if (inc)       regs[REG_PC] <= regs[REG_PC] + DATA_WIDTH'(1);
    end
  end

  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/cpu_datapath.sv
// Bus resolution, register transfers, adder A/G and XOR B/H for the CPU.
// Bus is combinational; every transfer lands on the next rising edge.
// No backpressure; multi-driver cycles zero the bus, drop loads, set bus_err.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            en_reg,
  input  logic [10:0]           tri_reg,
  input  logic [5:0]            general_reg,
  input  logic                  addclr,
  input  logic                  xorclr,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            dbg_sel,
  output logic [DATA_WIDTH-1:0] bus,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  bus_err
);

  logic [7:0][DATA_WIDTH-1:0] regs;
  logic [DATA_WIDTH-1:0]      a_q, b_q, g_q, h_q;
  logic [DATA_WIDTH-1:0]      bus_mux;
  logic [NUM_DRV-1:0]         drv;
  logic                       contention;

  assign drv        = {general_reg[GEN_B_TRI], general_reg[GEN_A_TRI], tri_reg};
  assign contention = multi_hot(drv);

  // OR of gated sources; correct whenever at most one driver is active
  always_comb begin
    bus_mux = '0;
    for (int k = 0; k < 8; k++) begin
      if (drv[k]) bus_mux |= regs[k];
    end
    if (drv[TRI_EXT]) bus_mux |= data_in;
    if (drv[TRI_H])   bus_mux |= h_q;
    if (drv[TRI_G])   bus_mux |= g_q;
    if (drv[DRV_A])   bus_mux |= a_q;
    if (drv[DRV_B])   bus_mux |= b_q;
  end

  assign bus = contention ? '0 : bus_mux;
  assign pc  = regs[REG_PC];

  cpu_reg_file #(.DATA_WIDTH(DATA_WIDTH)) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (contention ? 8'h00 : en_reg),
    .ld_dat   (bus),
    .inc      (done),
    .dbg_sel  (dbg_sel),
    .regs     (regs),
    .dbg_data (dbg_data)
  );

  // Adder operand and result; clear beats load, G uses the pre-edge A
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      g_q <= '0;
    end else begin
      if (addclr)                                       a_q <= '0;
      else if (general_reg[GEN_A_EN] && !contention)    a_q <= bus;
      if (general_reg[GEN_G_EN])                        g_q <= a_q + bus;
    end
  end

  // XOR operand and result; clear beats load, H uses the pre-edge B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q <= '0;
      h_q <= '0;
    end else begin
      if (xorclr)                                       b_q <= '0;
      else if (general_reg[GEN_B_EN] && !contention)    b_q <= bus;
      if (general_reg[GEN_H_EN])                        h_q <= b_q ^ bus;
    end
  end

  // Contention flag is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            bus_err <= 1'b0;
    else if (contention) bus_err <= 1'b1;
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Table-driven and randomized checks of cpu_datapath against a reference model.
// Inputs change 1 after the rising edge; outputs sampled before the next edge.
// Ends with a single summary line.
module tb_cpu_datapath;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg;
  logic [10:0] tri_reg;
  logic [5:0]  general_reg;
  logic        addclr, xorclr, done;
  logic [7:0]  data_in;
  logic [2:0]  dbg_sel;
  logic [7:0]  bus, pc, dbg_data;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  cpu_datapath #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en_reg(en_reg), .tri_reg(tri_reg),
    .general_reg(general_reg), .addclr(addclr), .xorclr(xorclr), .done(done),
    .data_in(data_in), .dbg_sel(dbg_sel), .bus(bus), .pc(pc),
    .dbg_data(dbg_data), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_r [8];
  logic [7:0] m_a, m_b, m_g, m_h;
  logic       m_err;

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_a = 0; m_b = 0; m_g = 0; m_h = 0; m_err = 0;
  endtask

  function automatic int n_drivers(input logic [10:0] t, input logic [5:0] g);
    return $countones({g[1], g[4], t});
  endfunction

  function automatic logic [7:0] m_bus(input logic [10:0] t, input logic [5:0] g,
                                       input logic [7:0] di);
    if (n_drivers(t, g) != 1) return 8'h00;
    for (int i = 0; i < 8; i++) if (t[i]) return m_r[i];
    if (t[8])  return di;
    if (t[9])  return m_h;
    if (t[10]) return m_g;
    if (g[4])  return m_a;
    return m_b;
  endfunction

  task automatic m_update(input logic [10:0] t, input logic [7:0] e, input logic [5:0] g,
                          input logic ac, input logic xc, input logic dn, input logic [7:0] di);
    logic [7:0] bv, old_a, old_b;
    logic ok;
    bv = m_bus(t, g, di);
    ok = n_drivers(t, g) < 2;
    old_a = m_a; old_b = m_b;
    for (int k = 0; k < 7; k++) if (e[k] && ok) m_r[k] = bv;
    if (e[7] && ok) m_r[7] = bv;
    else if (dn)    m_r[7] = m_r[7] + 8'd1;
    if (g[3]) m_g = old_a + bv;
    if (g[0]) m_h = old_b ^ bv;
    if (ac) m_a = 0; else if (g[5] && ok) m_a = bv;
    if (xc) m_b = 0; else if (g[2] && ok) m_b = bv;
    if (!ok) m_err = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at time %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, check bus against model, clock, check state against model
  task automatic step(input logic [10:0] t, input logic [7:0] e, input logic [5:0] g,
                      input logic ac, input logic xc, input logic dn,
                      input logic [7:0] di, input logic [2:0] ds,
                      output logic [7:0] obus, output logic [7:0] odbg);
    tri_reg = t; en_reg = e; general_reg = g; addclr = ac; xorclr = xc;
    done = dn; data_in = di; dbg_sel = ds;
    #1;
    obus = bus;
    chk("bus", bus, m_bus(t, g, di));
    m_update(t, e, g, ac, xc, dn, di);
    @(posedge clk);
    #1;
    odbg = dbg_data;
    chk("pc", pc, m_r[7]);
    chk("bus_err", {7'd0, bus_err}, {7'd0, m_err});
    chk("dbg_data", dbg_data, m_r[ds]);
  endtask

  task automatic idle(input logic [2:0] ds, output logic [7:0] odbg);
    logic [7:0] ob;
    step(11'h0, 8'h0, 6'h0, 1'b0, 1'b0, 1'b0, 8'h00, ds, ob, odbg);
  endtask

  // Asynchronous reset asserted mid-cycle, released after the following edge
  task automatic do_reset();
    tri_reg = 11'h100; en_reg = 0; general_reg = 0; addclr = 0; xorclr = 0;
    done = 0; data_in = 8'hA5; dbg_sel = 3'd7;
    #2;
    rst = 1'b0;
    m_clear();
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_bus_err", {7'd0, bus_err}, 8'h00);
    chk("rst_bus_ext", bus, 8'hA5);
    chk("rst_dbg", dbg_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tri_reg = 0;
  endtask

  typedef struct {
    logic [10:0] t;
    logic [7:0]  e;
    logic [5:0]  g;
    logic        ac, xc, dn;
    logic [7:0]  di;
    logic [2:0]  ds;
    logic [7:0]  xbus, xdbg;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [7:0] ob, od;
    logic [12:0] d13;
    logic [10:0] rt;
    logic [7:0]  re;
    logic [5:0]  rg;
    logic        rac, rxc, rdn;

    // LOAD / MOVE
    tbl[0]  = '{11'h100, 8'h08, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h5A, 3'd3, 8'h5A, 8'h5A};
    tbl[1]  = '{11'h008, 8'h40, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd6, 8'h5A, 8'h5A};
    // ADD with wrap: R1=F0, R2=20, A<-R1, G<-A+R2 with clear, R1<-G
    tbl[2]  = '{11'h100, 8'h02, 6'b000000, 1'b0, 1'b0, 1'b0, 8'hF0, 3'd1, 8'hF0, 8'hF0};
    tbl[3]  = '{11'h100, 8'h04, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h20, 3'd2, 8'h20, 8'h20};
    tbl[4]  = '{11'h002, 8'h00, 6'b100000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 8'hF0, 8'hF0};
    tbl[5]  = '{11'h004, 8'h00, 6'b001000, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 8'h20, 8'h20};
    tbl[6]  = '{11'h400, 8'h02, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h10, 8'h10};
    tbl[7]  = '{11'h000, 8'h00, 6'b010000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h00, 8'h10};
    // XOR: B<-CC, H<-B^AA with clear, R0<-H
    tbl[8]  = '{11'h100, 8'h00, 6'b000100, 1'b0, 1'b0, 1'b0, 8'hCC, 3'd0, 8'hCC, 8'h00};
    tbl[9]  = '{11'h100, 8'h00, 6'b000001, 1'b0, 1'b1, 1'b0, 8'hAA, 3'd0, 8'hAA, 8'h00};
    tbl[10] = '{11'h000, 8'h00, 6'b000010, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 8'h00};
    tbl[11] = '{11'h200, 8'h01, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h66, 8'h66};
    // PC load wins over done
    tbl[12] = '{11'h100, 8'h80, 6'b000000, 1'b0, 1'b0, 1'b1, 8'h40, 3'd7, 8'h40, 8'h40};
    // No driver: bus is zero even with data_in present
    tbl[13] = '{11'h000, 8'h00, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h77, 3'd3, 8'h00, 8'h5A};
    tbl[14] = '{11'h400, 8'h00, 6'b000000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 8'h10, 8'h40};

    rst = 1'b0; en_reg = 0; tri_reg = 0; general_reg = 0;
    addclr = 0; xorclr = 0; done = 0; data_in = 0; dbg_sel = 0;
    m_clear();
    #2;
    chk("init_pc", pc, 8'h00);
    chk("init_bus_err", {7'd0, bus_err}, 8'h00);
    chk("init_dbg", dbg_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].t, tbl[i].e, tbl[i].g, tbl[i].ac, tbl[i].xc, tbl[i].dn,
           tbl[i].di, tbl[i].ds, ob, od);
      chk($sformatf("tbl%0d_bus", i), ob, tbl[i].xbus);
      chk($sformatf("tbl%0d_dbg", i), od, tbl[i].xdbg);
    end

    // PC wraps after 256 increments from zero
    do_reset();
    for (int i = 0; i < 255; i++) step(11'h0, 8'h0, 6'h0, 0, 0, 1, 8'h00, 3'd7, ob, od);
    chk("pc_ff", pc, 8'hFF);
    step(11'h0, 8'h0, 6'h0, 0, 0, 1, 8'h00, 3'd7, ob, od);
    chk("pc_wrap", pc, 8'h00);

    // Reset in the middle of an ADD
    step(11'h100, 8'h02, 6'h00, 0, 0, 0, 8'h33, 3'd1, ob, od);
    step(11'h100, 8'h00, 6'b000100, 0, 0, 0, 8'h44, 3'd1, ob, od);
    step(11'h002, 8'h00, 6'b100000, 0, 0, 1, 8'h00, 3'd1, ob, od);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle(3'(k), od);
      chk($sformatf("rst_r%0d", k), od, 8'h00);
    end
    step(11'h000, 8'h0, 6'b010000, 0, 0, 0, 8'h00, 3'd0, ob, od);
    chk("rst_a", ob, 8'h00);
    step(11'h000, 8'h0, 6'b000010, 0, 0, 0, 8'h00, 3'd0, ob, od);
    chk("rst_b", ob, 8'h00);
    step(11'h400, 8'h0, 6'h00, 0, 0, 0, 8'h00, 3'd0, ob, od);
    chk("rst_g", ob, 8'h00);

    // Contention: R1 and R2 drive together while R4 is enabled
    step(11'h100, 8'h02, 6'h00, 0, 0, 0, 8'h11, 3'd1, ob, od);
    step(11'h100, 8'h04, 6'h00, 0, 0, 0, 8'h22, 3'd2, ob, od);
    step(11'h100, 8'h10, 6'h00, 0, 0, 0, 8'h44, 3'd4, ob, od);
    tri_reg = 11'h006; en_reg = 8'h10; #1;
    chk("pre_err", {7'd0, bus_err}, 8'h00);
    step(11'h006, 8'h10, 6'h00, 0, 0, 0, 8'h00, 3'd4, ob, od);
    chk("cont_bus", ob, 8'h00);
    chk("cont_r4", od, 8'h44);
    chk("cont_err", {7'd0, bus_err}, 8'h01);
    for (int i = 0; i < 3; i++) idle(3'd4, od);
    chk("err_sticky", {7'd0, bus_err}, 8'h01);
    do_reset();

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      case ($urandom_range(0, 9))
        0: d13 = '0;
        1: d13 = (13'd1 << $urandom_range(0, 12)) | (13'd1 << $urandom_range(0, 12));
        default: d13 = 13'd1 << $urandom_range(0, 12);
      endcase
      rt = d13[10:0];
      rg = {($urandom_range(0, 3) == 0), d13[11], ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), d13[12], ($urandom_range(0, 3) == 0)};
      re = '0;
      for (int k = 0; k < 8; k++) re[k] = ($urandom_range(0, 6) == 0);
      rac = ($urandom_range(0, 4) == 0);
      rxc = ($urandom_range(0, 4) == 0);
      rdn = ($urandom_range(0, 2) == 0);
      if (n_drivers(rt, rg) > 1 && re[7]) rdn = 1'b0;
      step(rt, re, rg, rac, rxc, rdn, 8'($urandom), 3'($urandom_range(0, 7)), ob, od);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
